// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding and
// default geometry/timeout. The CHK state exists only when IM_LOADER_CHKSUM_EN
// is defined.
package im_loader_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_TIMEOUT = 1023;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_HI,
    ST_LO,
    ST_WR,
    ST_DONE,
    ST_ERR
`ifdef IM_LOADER_CHKSUM_EN
    , ST_CHK
`endif
  } state_t;

endpackage

// File: rtl/im_loader_if.sv
// Handshake and memory-write bundle between a byte source, the loader and
// the instruction memory. master = byte source / observer, slave = loader.
interface im_loader_if import im_loader_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [15:0]       im_wdata;
  logic              core_rst;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, im_we, im_waddr, im_wdata, core_rst, busy, done, err
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, im_we, im_waddr, im_wdata, core_rst, busy, done, err
  );
endinterface

// File: rtl/im_loader_wdog.sv
// Idle-timeout watchdog. Down-counter reloaded with TIMEOUT on clear and
// decremented on each enabled cycle; expired flags terminal count (zero).
module im_loader_wdog import im_loader_pkg::*; #(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  // Reload on clear, count idle cycles down, hold at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (clear)
      cnt <= CNT_W'(TIMEOUT);
    else if (enable && (cnt != '0))
      cnt <= cnt - CNT_W'(1);
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/im_loader.sv
// Instruction-memory loader: receives a length byte followed by big-endian
// 16-bit words over a valid/ready byte stream, writes them to sequential
// addresses starting at 0, and holds the core in reset until the load ends.
// Optional feature macro: IM_LOADER_CHKSUM_EN (trailing XOR checksum byte).
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | after reset, waiting for start
// LEN     | waiting for length byte (0 = full 2^ADDR_W words)
// HI      | waiting for upper byte of next word
// LO      | waiting for lower byte of next word
// WR      | one-cycle memory write strobe, address advances
// CHK     | waiting for checksum byte (IM_LOADER_CHKSUM_EN only)
// DONE    | load succeeded, core released, waiting for start
// ERR     | load aborted, core held, waiting for start
module im_loader import im_loader_pkg::*; #(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  im_loader_if.slave   bus
);
  // Word counter must hold 2^ADDR_W as well as any 8-bit length.
  localparam int CNT_W = ((ADDR_W > 8) ? ADDR_W : 8) + 1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  words_left;
  logic [15:0]       wdata;
  logic              wait_st, accept, start_go, last_word, expired;
  logic              in_ready_i, we_i, core_rst_i, busy_i, done_i, err_i;
`ifdef IM_LOADER_CHKSUM_EN
  logic [7:0]        chk;
`endif

`ifdef IM_LOADER_CHKSUM_EN
  assign wait_st = (state == ST_LEN) || (state == ST_HI) ||
                   (state == ST_LO)  || (state == ST_CHK);
`else
  assign wait_st = (state == ST_LEN) || (state == ST_HI) || (state == ST_LO);
`endif
  assign accept    = bus.in_valid && in_ready_i;
  assign start_go  = bus.start &&
                     ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
  assign last_word = (words_left == CNT_W'(1));

  im_loader_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept || start_go),
    .enable  (wait_st),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  // Next-state decode; timeout takes precedence over an arriving byte.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (bus.start) state_nx = ST_LEN;
      ST_LEN: begin
        if (expired)     state_nx = ST_ERR;
        else if (accept) state_nx = ST_HI;
      end
      ST_HI: begin
        if (expired)     state_nx = ST_ERR;
        else if (accept) state_nx = ST_LO;
      end
      ST_LO: begin
        if (expired)     state_nx = ST_ERR;
        else if (accept) state_nx = ST_WR;
      end
      ST_WR: begin
        if (!last_word)  state_nx = ST_HI;
`ifdef IM_LOADER_CHKSUM_EN
        else             state_nx = ST_CHK;
`else
        else             state_nx = ST_DONE;
`endif
      end
`ifdef IM_LOADER_CHKSUM_EN
      ST_CHK: begin
        if (expired)     state_nx = ST_ERR;
        else if (accept) state_nx = (bus.in_data == chk) ? ST_DONE : ST_ERR;
      end
`endif
      default:           state_nx = ST_IDLE;
    endcase
  end

  // Moore outputs; in_ready drops on the expiry cycle so no byte is taken.
  always_comb begin
    in_ready_i = 1'b0;
    we_i       = 1'b0;
    core_rst_i = 1'b1;
    busy_i     = 1'b0;
    done_i     = 1'b0;
    err_i      = 1'b0;
    case (state)
      ST_LEN, ST_HI, ST_LO: begin
        in_ready_i = !expired;
        busy_i     = 1'b1;
      end
`ifdef IM_LOADER_CHKSUM_EN
      ST_CHK: begin
        in_ready_i = !expired;
        busy_i     = 1'b1;
      end
`endif
      ST_WR: begin
        we_i   = 1'b1;
        busy_i = 1'b1;
      end
      ST_DONE: begin
        core_rst_i = 1'b0;
        done_i     = 1'b1;
      end
      ST_ERR:  err_i = 1'b1;
      default: ;
    endcase
  end

  // Datapath: word count, write address, word assembly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr       <= '0;
      words_left <= '0;
      wdata      <= '0;
    end else begin
      if (start_go) begin
        addr       <= '0;
        words_left <= '0;
      end else if (accept && (state == ST_LEN)) begin
        words_left <= (bus.in_data == 8'd0) ? CNT_W'({1'b1, {ADDR_W{1'b0}}})
                                            : CNT_W'(bus.in_data);
      end else if (accept && (state == ST_HI)) begin
        wdata[15:8] <= bus.in_data;
      end else if (accept && (state == ST_LO)) begin
        wdata[7:0] <= bus.in_data;
      end else if (state == ST_WR) begin
        addr       <= addr + ADDR_W'(1);
        words_left <= words_left - CNT_W'(1);
      end
    end
  end

`ifdef IM_LOADER_CHKSUM_EN
  // Running XOR of the length and all data bytes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      chk <= '0;
    else if (start_go)
      chk <= '0;
    else if (accept && (state != ST_CHK))
      chk <= chk ^ bus.in_data;
  end
`endif

  assign bus.in_ready = in_ready_i;
  assign bus.im_we    = we_i;
  assign bus.im_waddr = addr;
  assign bus.im_wdata = wdata;
  assign bus.core_rst = core_rst_i;
  assign bus.busy     = busy_i;
  assign bus.done     = done_i;
  assign bus.err      = err_i;
endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: directed scenarios plus randomized
// loads checked against a word-list / XOR model. Honors IM_LOADER_CHKSUM_EN.
module tb_im_loader;
  import im_loader_pkg::*;

  localparam int TO = 30;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic [7:0]  wa_q[$];
  logic [15:0] wd_q[$];
  logic [15:0] wq[$];

  im_loader_if #(.ADDR_W(8)) bus ();
  im_loader #(.ADDR_W(8), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Record every write strobe seen mid-cycle.
  always @(negedge clk)
    if (rst && (bus.im_we === 1'b1)) begin
      wa_q.push_back(bus.im_waddr);
      wd_q.push_back(bus.im_wdata);
    end

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "bench stalled");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  function automatic logic [5:0] ovec();
    return {bus.in_ready, bus.im_we, bus.core_rst, bus.busy, bus.done, bus.err};
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got = 1'b0;
    bus.in_valid = 1'b0;
    tick(gap);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("byte_accept", {31'd0, got}, 32'd1);
  endtask

  task automatic run_load(input logic [7:0] n, input int max_gap,
                          input bit bad_chk, input bit poke_start);
    logic [7:0] x;
    int nw;
    bit fin;
    bit ok;
    nw = (n == 8'd0) ? 256 : int'(n);
    wa_q.delete();
    wd_q.delete();
    pulse_start();
    #2;
    chk("start_clears", {29'd0, bus.busy, bus.done, bus.err}, 32'b100);
    send_byte(n, $urandom_range(max_gap, 0));
    x = n;
    for (int i = 0; i < nw; i++) begin
      if (poke_start && (i % 64 == 10)) pulse_start();
      send_byte(wq[i][15:8], $urandom_range(max_gap, 0));
      send_byte(wq[i][7:0], $urandom_range(max_gap, 0));
      x = x ^ wq[i][15:8] ^ wq[i][7:0];
    end
    ok = 1'b1;
`ifdef IM_LOADER_CHKSUM_EN
    send_byte(bad_chk ? ~x : x, $urandom_range(max_gap, 0));
    ok = !bad_chk;
`endif
    fin = 1'b0;
    for (int k = 0; k < 8 && !fin; k++) begin
      @(negedge clk);
      fin = bus.done | bus.err;
      if (!fin) begin @(posedge clk); #1; end
    end
    chk("load_finish", {31'd0, fin}, 32'd1);
    chk("end_flags", {28'd0, bus.done, bus.err, bus.core_rst, bus.busy},
        {28'd0, ok, !ok, !ok, 1'b0});
    chk("wr_count", wa_q.size(), nw);
    for (int i = 0; i < nw && i < wa_q.size(); i++) begin
      chk("wr_addr", wa_q[i], i);
      chk("wr_data", wd_q[i], wq[i]);
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_words(input int nw);
    wq.delete();
    for (int i = 0; i < nw; i++) wq.push_back(16'($urandom));
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Values while reset is held.
    #3;
    chk("rst_outputs", ovec(), 6'b001000);
    chk("rst_waddr", bus.im_waddr, 0);
    chk("rst_wdata", bus.im_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Released, no start: everything parked for 100 cycles.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_hold", ovec(), 6'b001000);
    end
    @(posedge clk); #1;

    // Two-word directed load.
    wq = {16'h1234, 16'hABCD};
    run_load(8'd2, 0, 1'b0, 1'b0);

    // Bytes offered while in DONE are not consumed.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    tick(5);
    @(negedge clk);
    chk("done_ignore", ovec(), {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    chk("done_ignore_wr", wa_q.size(), 2);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

`ifdef IM_LOADER_CHKSUM_EN
    // Checksum mismatch: word written, load still fails.
    wq = {16'h0001};
    run_load(8'd1, 0, 1'b1, 1'b0);
`endif

    // Timeout after the length byte.
    wa_q.delete();
    wd_q.delete();
    pulse_start();
    send_byte(8'd3, 0);
    tick(TO - 1);
    @(negedge clk);
    chk("to_not_yet", {30'd0, bus.busy, bus.err}, 32'b10);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 4 && !seen; k++) begin
        @(posedge clk); #1;
        @(negedge clk);
        seen = bus.err;
      end
      chk("to_err", {31'd0, seen}, 32'd1);
    end
    chk("to_flags", {29'd0, bus.done, bus.core_rst, bus.busy}, 32'b010);
    chk("to_no_wr", wa_q.size(), 0);
    @(posedge clk); #1;

    // Recovery load after the abort.
    rand_words(4);
    run_load(8'd4, 2, 1'b0, 1'b0);

    // Random loads, small gaps, random checksum corruption.
    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(12, 1);
      rand_words(n);
      run_load(8'(n), 3, 1'($urandom_range(1, 0)), 1'b0);
    end

    // Gaps up to one short of the timeout never abort.
    rand_words(3);
    run_load(8'd3, TO - 1, 1'b0, 1'b0);

    // Reset mid-load after the third word of five.
    rand_words(5);
    wa_q.delete();
    wd_q.delete();
    pulse_start();
    send_byte(8'd5, 0);
    for (int i = 0; i < 3; i++) begin
      send_byte(wq[i][15:8], 0);
      send_byte(wq[i][7:0], 0);
    end
    tick(1);
    chk("mid_wr_count", wa_q.size(), 3);
    rst = 1'b0;
    #1;
    chk("mid_rst_out", ovec(), 6'b001000);
    chk("mid_rst_waddr", bus.im_waddr, 0);
    chk("mid_rst_wdata", bus.im_wdata, 0);
    tick(2);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      tick(1);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("mid_after_out", ovec(), 6'b001000);
    chk("mid_after_wr", wa_q.size(), 3);
    for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
      chk("mid_addr", wa_q[i], i);
      chk("mid_data", wd_q[i], wq[i]);
    end
    @(posedge clk); #1;

    // Full-depth load (length 0), data = address, stray starts while busy.
    wq.delete();
    for (int i = 0; i < 256; i++) wq.push_back(16'(i));
    run_load(8'd0, 0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
